// File: rtl/prt_dp_axil_lb_bridge.sv
// AXI4-lite slave to simple local-bus master bridge, one transaction in flight.
// Optional read timeout (SLVERR response) enabled by PRT_DP_AXIL_LB_BRIDGE_TIMEOUT_EN.
module prt_dp_axil_lb_bridge #(
    parameter int unsigned P_ADR_WIDTH = 32,
    parameter int unsigned P_TIMEOUT   = 255
) (
    input  logic                   CLK_IN,
    input  logic                   RST_IN,

    input  logic [P_ADR_WIDTH-1:0] AXIL_AWADR,
    input  logic                   AXIL_AWVALID,
    output logic                   AXIL_AWREADY,
    input  logic [31:0]            AXIL_WDATA,
    input  logic                   AXIL_WVALID,
    output logic                   AXIL_WREADY,
    output logic [1:0]             AXIL_BRESP,
    output logic                   AXIL_BVALID,
    input  logic                   AXIL_BREADY,
    input  logic [P_ADR_WIDTH-1:0] AXIL_ARADR,
    input  logic                   AXIL_ARVALID,
    output logic                   AXIL_ARREADY,
    output logic [31:0]            AXIL_RDATA,
    output logic [1:0]             AXIL_RRESP,
    output logic                   AXIL_RVALID,
    input  logic                   AXIL_RREADY,

    output logic [P_ADR_WIDTH-1:0] LB_ADR,
    output logic                   LB_WR,
    output logic                   LB_RD,
    output logic [31:0]            LB_DIN,
    input  logic [31:0]            LB_DOUT,
    input  logic                   LB_VLD
);

    typedef enum logic [2:0] {
        IDLE,
        WR,
        BRSP,
        RD,
        RWAIT,
        RRSP
    } state_t;

    state_t state, state_nxt;

    logic wr_hs;
    logic rd_hs;
    logic rd_done;
    logic rd_err;
    logic tmo_hit;

    logic [P_ADR_WIDTH-1:0] adr_q;
    logic [31:0]            din_q;
    logic                   wr_q;
    logic                   rd_q;
    logic                   bvalid_q;
    logic [1:0]             bresp_q;
    logic                   rvalid_q;
    logic [31:0]            rdata_q;
    logic [1:0]             rresp_q;

`ifdef PRT_DP_AXIL_LB_BRIDGE_TIMEOUT_EN
    localparam logic [15:0] TMO_LIM = 16'(P_TIMEOUT);

    logic [15:0] tmo_cnt;

    assign tmo_hit = (tmo_cnt == TMO_LIM);

    always_ff @(posedge CLK_IN) begin
        if (RST_IN) begin
            tmo_cnt <= '0;
        end else if (rd_hs) begin
            tmo_cnt <= '0;
        end else if ((state == RD) || (state == RWAIT)) begin
            tmo_cnt <= tmo_cnt + 16'd1;
        end
    end
`else
    assign tmo_hit = 1'b0;
`endif

    always_comb begin
        state_nxt    = state;
        wr_hs        = 1'b0;
        rd_hs        = 1'b0;
        rd_done      = 1'b0;
        rd_err       = 1'b0;
        AXIL_AWREADY = 1'b0;
        AXIL_WREADY  = 1'b0;
        AXIL_ARREADY = 1'b0;
        case (state)
            IDLE: begin
                // Write and read ready are mutually exclusive; write takes priority.
                if (!RST_IN) begin
                    AXIL_AWREADY = AXIL_AWVALID & AXIL_WVALID;
                    AXIL_WREADY  = AXIL_AWVALID & AXIL_WVALID;
                    AXIL_ARREADY = AXIL_ARVALID & ~(AXIL_AWVALID & AXIL_WVALID);
                end
                wr_hs = AXIL_AWREADY;
                rd_hs = AXIL_ARREADY;
                if (wr_hs) begin
                    state_nxt = WR;
                end else if (rd_hs) begin
                    state_nxt = RD;
                end
            end
            WR: begin
                state_nxt = BRSP;
            end
            BRSP: begin
                if (AXIL_BREADY) begin
                    state_nxt = IDLE;
                end
            end
            RD, RWAIT: begin
                if (LB_VLD) begin
                    rd_done   = 1'b1;
                    state_nxt = RRSP;
                end else if (tmo_hit) begin
                    rd_err    = 1'b1;
                    state_nxt = RRSP;
                end else begin
                    state_nxt = RWAIT;
                end
            end
            RRSP: begin
                if (AXIL_RREADY) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK_IN) begin
        if (RST_IN) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge CLK_IN) begin
        if (RST_IN) begin
            adr_q    <= '0;
            din_q    <= '0;
            wr_q     <= 1'b0;
            rd_q     <= 1'b0;
            bvalid_q <= 1'b0;
            bresp_q  <= '0;
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
            rresp_q  <= '0;
        end else begin
            wr_q <= wr_hs;
            rd_q <= rd_hs;

            if (wr_hs) begin
                adr_q <= AXIL_AWADR;
                din_q <= AXIL_WDATA;
            end else if (rd_hs) begin
                adr_q <= AXIL_ARADR;
            end

            if (state == WR) begin
                bvalid_q <= 1'b1;
                bresp_q  <= 2'b00;
            end else if ((state == BRSP) && AXIL_BREADY) begin
                bvalid_q <= 1'b0;
            end

            if (rd_done) begin
                rvalid_q <= 1'b1;
                rdata_q  <= LB_DOUT;
                rresp_q  <= 2'b00;
            end else if (rd_err) begin
                rvalid_q <= 1'b1;
                rdata_q  <= '0;
                rresp_q  <= 2'b10;
            end else if ((state == RRSP) && AXIL_RREADY) begin
                rvalid_q <= 1'b0;
            end
        end
    end

    assign LB_ADR      = adr_q;
    assign LB_DIN      = din_q;
    assign LB_WR       = wr_q;
    assign LB_RD       = rd_q;
    assign AXIL_BVALID = bvalid_q;
    assign AXIL_BRESP  = bresp_q;
    assign AXIL_RVALID = rvalid_q;
    assign AXIL_RDATA  = rdata_q;
    assign AXIL_RRESP  = rresp_q;

endmodule

// File: doc/prt_dp_axil_lb_bridge.md
PRT_DP_AXIL_LB_BRIDGE -- requirements
Module: prt_dp_axil_lb_bridge

Interface
REQ-001 SHALL have parameter P_ADR_WIDTH, default 32, AXI4-lite and local bus address width.
REQ-002 SHALL have parameter P_TIMEOUT, default 255, read-timeout limit in clock cycles (range 2..65535).
REQ-003 SHALL have ports:
- CLK_IN  in  1  clock; single clock domain.
- RST_IN  in  1  reset; synchronous, active-high.
REQ-004 SHALL have AXI4-lite slave ports:
- AXIL_AWADR  in  P_ADR_WIDTH  write address.
- AXIL_AWVALID  in  1  write address valid.
- AXIL_AWREADY  out  1  write address ready.
- AXIL_WDATA  in  32  write data.
- AXIL_WVALID  in  1  write data valid.
- AXIL_WREADY  out  1  write data ready.
- AXIL_BRESP  out  2  write response.
- AXIL_BVALID  out  1  write response valid.
- AXIL_BREADY  in  1  write response ready.
- AXIL_ARADR  in  P_ADR_WIDTH  read address.
- AXIL_ARVALID  in  1  read address valid.
- AXIL_ARREADY  out  1  read address ready.
- AXIL_RDATA  out  32  read data.
- AXIL_RRESP  out  2  read response.
- AXIL_RVALID  out  1  read data valid.
- AXIL_RREADY  in  1  read data ready.
REQ-005 SHALL have local bus master ports:
- LB_ADR  out  P_ADR_WIDTH  address.
- LB_WR  out  1  write strobe.
- LB_RD  out  1  read strobe.
- LB_DIN  out  32  write data to slave.
- LB_DOUT  in  32  read data from slave.
- LB_VLD  in  1  read data valid.

Function
REQ-006 SHALL implement FSM states IDLE, WR, BRSP, RD, RWAIT, RRSP; one transaction outstanding at a time.
REQ-007 In IDLE, AXIL_AWREADY and AXIL_WREADY SHALL both equal AXIL_AWVALID & AXIL_WVALID (joint handshake only; no partial acceptance).
REQ-008 In IDLE, AXIL_ARREADY SHALL equal AXIL_ARVALID & ~(AXIL_AWVALID & AXIL_WVALID); write wins a simultaneous request.
REQ-009 All ready outputs SHALL be 0 outside IDLE.
REQ-010 Write handshake in cycle N SHALL register LB_ADR/LB_DIN and pulse LB_WR high for exactly cycle N+1 (state WR).
REQ-011 AXIL_BVALID SHALL rise in cycle N+2 with AXIL_BRESP=2'b00, hold until AXIL_BREADY, then return to IDLE in the next cycle.
REQ-012 Read handshake in cycle N SHALL register LB_ADR and pulse LB_RD high for exactly cycle N+1 (state RD), then enter RWAIT.
REQ-013 In RD or RWAIT, LB_VLD=1 in cycle M SHALL capture LB_DOUT into AXIL_RDATA and assert AXIL_RVALID in cycle M+1, AXIL_RRESP=2'b00.
REQ-014 AXIL_RVALID, AXIL_RDATA and AXIL_RRESP SHALL stay stable until AXIL_RREADY; FSM returns to IDLE the cycle after.
REQ-015 LB_VLD SHALL be ignored in every state other than RD/RWAIT.
REQ-016 LB_ADR SHALL hold its last value between transactions; LB_DIN updates only on write handshake.

Reset
REQ-017 RST_IN high at a clock edge SHALL force IDLE, abort any transaction and zero LB_WR, LB_RD, LB_ADR, LB_DIN, AXIL_BVALID, AXIL_BRESP, AXIL_RVALID, AXIL_RDATA, AXIL_RRESP and the timeout counter.
REQ-018 While RST_IN is high, all ready outputs SHALL be 0.

Configuration
REQ-019 Macro PRT_DP_AXIL_LB_BRIDGE_TIMEOUT_EN defined: a 16-bit counter clears on read handshake and increments in RD/RWAIT; when it reaches P_TIMEOUT without LB_VLD, the bridge SHALL assert AXIL_RVALID next cycle with AXIL_RDATA=0, AXIL_RRESP=2'b10 (SLVERR).
REQ-020 Macro not defined: no counter; RWAIT SHALL wait indefinitely for LB_VLD; AXIL_RRESP always 2'b00.

Verification
REQ-021 AWADR=0x10, WDATA=0xDEADBEEF, AW/W valid same cycle, BREADY=1 -> LB_WR one cycle with LB_ADR=0x10, LB_DIN=0xDEADBEEF; BVALID 2 cycles after handshake, BRESP=00.
REQ-022 ARADR=0x24, slave returns LB_VLD with 0x12345678 three cycles after LB_RD, RREADY low 4 cycles -> RDATA=0x12345678 held with RVALID for 4 cycles, single RVALID handshake.
REQ-023 AWVALID, WVALID, ARVALID all high same cycle -> write completes first, ARREADY only after BVALID handshake, read then completes.
REQ-024 AWVALID high, WVALID low 5 cycles -> AWREADY stays 0, no LB_WR, until WVALID rises.
REQ-025 TIMEOUT_EN, P_TIMEOUT=8, LB_VLD never asserted -> RVALID with RDATA=0, RRESP=10; late LB_VLD ignored; without macro RVALID never asserts.
REQ-026 RST_IN pulsed during RWAIT -> all outputs zero next cycle, FSM in IDLE, fresh read completes normally.
